// File: rtl/alu_iter_if.sv
// Request/response bundle for alu_iter: operands and opcode in, registered result,
// NZCV flags, error, busy and done out.
interface alu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [3:0]       alu_flags;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output start, opcode, a, b,
        input  result, alu_flags, err, busy, done
    );

    modport slave (
        input  start, opcode, a, b,
        output result, alu_flags, err, busy, done
    );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle logic/add/sub/shift ops, shift-add MUL and restoring
// DIV/MOD. Division hardware is present only when ALU_ITER_DIV_EN is defined.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_iter_if.slave alu
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WVAL     = WIDTH'(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] res;
    logic             c_f, v_f, e_f;
    logic             go_iter;
`ifdef ALU_ITER_DIV_EN
    logic [WIDTH+1:0] div_trial;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        done_d   = 1'b0;
        res      = '0;
        c_f      = 1'b0;
        v_f      = 1'b0;
        e_f      = 1'b0;
        go_iter  = 1'b0;
        add_w    = {1'b0, a_q} + {1'b0, b_q};
        sub_w    = {1'b0, a_q} - {1'b0, b_q};
        // {hi,lo} shifts right one place per step; hi accumulates a when lo[0] is set
        mul_sum  = {1'b0, hi_q} + ({1'b0, a_q} & {(WIDTH + 1){lo_q[0]}});
`ifdef ALU_ITER_DIV_EN
        // Restoring step: hi is the partial remainder, lo shifts dividend out / quotient in
        div_trial = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, b_q};
`endif

        case (state_q)
            S_IDLE: begin
                // done_q marks the pulse cycle, in which a new start is not taken
                if (alu.start && !done_q) begin
                    op_d  = alu.opcode;
                    a_d   = alu.a;
                    b_d   = alu.b;
                    hi_d  = '0;
                    lo_d  = (alu.opcode == OP_MUL) ? alu.b : alu.a;
                    cnt_d = CNT_INIT;
`ifdef ALU_ITER_DIV_EN
                    go_iter = (alu.opcode == OP_MUL) ||
                              (((alu.opcode == OP_DIV) || (alu.opcode == OP_MOD)) &&
                               (alu.b != '0));
`else
                    go_iter = (alu.opcode == OP_MUL);
`endif
                    state_d = go_iter ? S_ITER : S_DONE;
                end
            end

            S_ITER: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
`ifdef ALU_ITER_DIV_EN
                    if (!div_trial[WIDTH+1]) begin
                        hi_d = div_trial[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
`endif
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                case (op_q)
                    OP_AND: res = a_q & b_q;
                    OP_OR:  res = a_q | b_q;
                    OP_XOR: res = a_q ^ b_q;
                    OP_ADD: begin
                        res = add_w[WIDTH-1:0];
                        c_f = add_w[WIDTH];
                        v_f = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_SUB: begin
                        res = sub_w[WIDTH-1:0];
                        c_f = ~sub_w[WIDTH];
                        v_f = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_MUL: begin
                        res = lo_q;
                        c_f = |hi_q;
                    end
                    OP_SHL: res = (b_q >= WVAL) ? '0 : (a_q << b_q);
                    OP_SHR: res = (b_q >= WVAL) ? '0 : (a_q >> b_q);
`ifdef ALU_ITER_DIV_EN
                    OP_DIV: begin
                        res = (b_q == '0) ? '1 : lo_q;
                        e_f = (b_q == '0);
                    end
                    OP_MOD: begin
                        res = (b_q == '0) ? a_q : hi_q;
                        e_f = (b_q == '0);
                    end
`endif
                    default: begin
                        res = '0;
                        e_f = 1'b1;
                    end
                endcase
                result_d = res;
                flags_d  = {res[WIDTH-1], (res == '0), c_f, v_f};
                err_d    = e_f;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign alu.result    = result_q;
    assign alu.alu_flags = flags_q;
    assign alu.err       = err_q;
    assign alu.done      = done_q;
    assign alu.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH=32); DIV/MOD expectations follow ALU_ITER_DIV_EN.
module tb_alu_iter;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    alu_iter_if #(.WIDTH(32)) bus ();

    alu_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .alu (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, count edges from acceptance to done, check outputs and the 1-cycle pulse.
    // With mid set, start is pulsed during the run and again in the done cycle.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_res,
                       input logic [3:0] exp_fl, input logic exp_err, input bit mid);
        int lat;
        @(negedge clk);
        bus.opcode = op;
        bus.a      = av;
        bus.b      = bv;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.a      = ~av;
        bus.b      = ~bv;
        bus.opcode = ~op;
        chk({tag, " busy_after_accept"}, 64'(bus.busy), 64'd1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (mid && lat == 10) begin
                bus.start  = 1'b1;
                bus.opcode = OP_ADD;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, " flags"}, 64'(bus.alu_flags), 64'(exp_fl));
        chk({tag, " err"}, 64'(bus.err), 64'(exp_err));
        chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        if (mid) begin
            bus.start  = 1'b1;
            bus.opcode = OP_ADD;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " done_pulse_end"}, 64'(bus.done), 64'd0);
        chk({tag, " idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.opcode = '0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(negedge clk);
        chk("reset result", 64'(bus.result), 64'd0);
        chk("reset flags", 64'(bus.alu_flags), 64'd0);
        chk("reset err", 64'(bus.err), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        rst = 1'b0;

        run("add_ovf",   OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 4'b1001, 1'b0, 1'b0);
        run("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'd1, 1, 32'h0000_0000, 4'b0110, 1'b0, 1'b0);
        run("sub_eq",    OP_SUB, 32'd5, 32'd5, 1, 32'h0000_0000, 4'b0110, 1'b0, 1'b0);
        run("sub_neg",   OP_SUB, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 4'b1000, 1'b0, 1'b0);
        run("and",       OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000, 4'b0000, 1'b0, 1'b0);
        run("or",        OP_OR,  32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F, 4'b1000, 1'b0, 1'b0);
        run("xor",       OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 32'h0000_0000, 4'b0100, 1'b0, 1'b0);
        run("shl31",     OP_SHL, 32'd1, 32'd31, 1, 32'h8000_0000, 4'b1000, 1'b0, 1'b0);
        run("shl32",     OP_SHL, 32'd1, 32'd32, 1, 32'h0000_0000, 4'b0100, 1'b0, 1'b0);
        run("shr31",     OP_SHR, 32'h8000_0000, 32'd31, 1, 32'h0000_0001, 4'b0000, 1'b0, 1'b0);
        run("shr_big",   OP_SHR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 4'b0100, 1'b0, 1'b0);
        run("mul_hi",    OP_MUL, 32'h0001_0000, 32'h0001_0000, 33, 32'h0000_0000, 4'b0110, 1'b0, 1'b1);
        run("mul_small", OP_MUL, 32'd7, 32'd6, 33, 32'h0000_002A, 4'b0000, 1'b0, 1'b0);
        run("mul_carry", OP_MUL, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE, 4'b1010, 1'b0, 1'b0);
`ifdef ALU_ITER_DIV_EN
        run("div",       OP_DIV, 32'd100, 32'd7, 33, 32'h0000_000E, 4'b0000, 1'b0, 1'b0);
        run("mod",       OP_MOD, 32'd100, 32'd7, 33, 32'h0000_0002, 4'b0000, 1'b0, 1'b0);
        run("div_max",   OP_DIV, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0);
        run("mod_max",   OP_MOD, 32'hFFFF_FFFF, 32'h10, 33, 32'h0000_000F, 4'b0000, 1'b0, 1'b0);
        run("div_zero",  OP_DIV, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0);
        run("mod_zero",  OP_MOD, 32'd9, 32'd0, 1, 32'h0000_0009, 4'b0000, 1'b1, 1'b0);
`else
        run("div_off",   OP_DIV, 32'd100, 32'd7, 1, 32'h0000_0000, 4'b0100, 1'b1, 1'b0);
        run("mod_off",   OP_MOD, 32'd100, 32'd7, 1, 32'h0000_0000, 4'b0100, 1'b1, 1'b0);
`endif
        run("add_small", OP_ADD, 32'd2, 32'd3, 1, 32'h0000_0005, 4'b0000, 1'b0, 1'b0);
        run("illegal",   4'b1100, 32'd1, 32'd2, 1, 32'h0000_0000, 4'b0100, 1'b1, 1'b0);

        // Reset during MUL iteration: outputs clear at once and no done follows
        @(negedge clk);
        bus.opcode = OP_MUL;
        bus.a      = 32'd3;
        bus.b      = 32'd4;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_mul busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst result", 64'(bus.result), 64'd0);
        chk("mid_rst flags", 64'(bus.alu_flags), 64'd0);
        chk("mid_rst err", 64'(bus.err), 64'd0);
        chk("mid_rst busy", 64'(bus.busy), 64'd0);
        chk("mid_rst done", 64'(bus.done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                chk("post_rst quiet", {62'd0, bus.done, bus.busy}, 64'd0);
            end
        end
        chk("post_rst done", 64'(bus.done), 64'd0);

        run("add_after_rst", OP_ADD, 32'd2, 32'd3, 1, 32'h0000_0005, 4'b0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
